alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Controller that shares one instance of the team's alu between NUM_REQ requesters, e.g. the EX stage and a branch/address helper.
- Per-requester valid/ready operand channel in; one registered result channel out, tagged with the owner id.
- Round-robin arbitration, one operation in flight, result held under backpressure.
- Sits in the execute region of the pipeline, between the requesting units and the alu.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OPCODE_LENGTH, 4, alu Operation width.
- NUM_REQ, 2, number of requesters (>=2).
- ID_W, $clog2(NUM_REQ), width of the owner id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_srca  in  NUM_REQ*DATA_WIDTH  packed SrcA; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_srcb  in  NUM_REQ*DATA_WIDTH  packed SrcB.
- req_op  in  NUM_REQ*OPCODE_LENGTH  packed alu opcode.
- rsp_valid  out  NUM_REQ  one-hot: result ready for that requester.
- rsp_ready  in  NUM_REQ  requester accepts its result.
- rsp_result  out  DATA_WIDTH  registered alu result.
- rsp_id  out  ID_W  index of the owning requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async on rst_n low): state=IDLE; req_ready=0; rsp_valid=0; rsp_result=0; rsp_id=0; busy=0; operand and op registers cleared; last_grant=NUM_REQ-1, so requester 0 wins first.
- Any in-flight operation is dropped on reset; no response is produced for it.
- FSM IDLE:
  - If any req_valid is high, round-robin picks g: first set bit starting at (last_grant+1) mod NUM_REQ, wrapping.
  - req_ready[g]=1 combinationally in the same cycle; capture srca/srcb/op of g and g into the owner register; go to EXEC.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- FSM EXEC: alu is driven from the captured registers; register its ALUResult into rsp_result and rsp_id=g; set rsp_valid[g]; go to RESP.
- FSM RESP:
  - Hold rsp_valid, rsp_result and rsp_id stable until rsp_ready[g] is high.
  - On handshake: clear rsp_valid, set last_grant=g, go to IDLE.
- Latency: request accepted at edge N gives rsp_valid at N+2. Throughput is 1 op per 3 cycles with rsp_ready held high.
- req_ready is 0 in EXEC and RESP. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- A requester may drop req_valid before it is granted; nothing is captured for it.
- Operands are sampled only in the accept cycle; later changes have no effect.
- rsp_ready bits for non-owners, and rsp_ready while rsp_valid=0, are ignored.
- Unknown opcodes pass through unchanged; the alu returns 0 and no error is flagged.
- Result width is DATA_WIDTH. ADD/SUB wrap modulo 2^DATA_WIDTH; EQ gives 1 or 0, zero-extended.

Optional Feature:
- Macro ALU_SHARE_B2B_EN.
- Defined:
  - In RESP, on the rsp handshake cycle, the arbiter also evaluates req_valid, with the pointer already advanced past g.
  - If a requester is selected: assert req_ready for it, capture its operands and go directly to EXEC.
  - Sustained throughput becomes 1 op per 2 cycles.
- Undefined: RESP always returns to IDLE; req_ready is strictly 0 outside IDLE.

Decomposition:
- Package alu_share_pkg:
  - opcode localparams OP_AND=4'b0000, OP_ADD=4'b0010, OP_SUB=4'b0110, OP_EQ=4'b1000;
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} share_state_t.
- Sub-module rr_arbiter (param NUM_REQ):
  - inputs req[NUM_REQ], last_grant, en;
  - outputs one-hot grant and grant_idx;
  - purely combinational, mask-plus-fallback scheme.
- alu is instantiated unchanged.

Test Plan:
- Reset, then req0 ADD 5+7 accepted at edge N -> rsp_valid=2'b01 at N+2, rsp_result=12, rsp_id=0, busy high N..N+2.
- req0 SUB 10-3 and req1 AND 0xF0F0&0x0FF0 both valid from reset, rsp_ready=2'b11 -> req0 first (7), then req1 (0x00F0); third round goes to req0 again.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result/rsp_id stable, req_ready=0 throughout, busy=1; release -> IDLE next cycle.
- EQ 0x1234 vs 0x1234 -> 1; EQ 0x1234 vs 0x1235 -> 0; op 4'b1111 -> 0; ADD 0xFFFFFFFF+1 -> 0.
- rst_n pulsed low during EXEC -> all outputs 0 immediately; no rsp_valid after release; with both requesting, req0 is granted first.
- Both requesting continuously, rsp_ready=2'b11 -> ids alternate 0,1,0,1; response spacing 2 cycles with ALU_SHARE_B2B_EN, 3 cycles without.

Source files
------------

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: alu opcodes and controller FSM states shared by the alu share controller
package alu_share_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} share_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational AND/ADD/SUB/EQ unit; unknown opcodes yield zero
module alu
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    assign ALUResult = (Operation == OP_AND) ? SrcA & SrcB :
                       (Operation == OP_ADD) ? SrcA + SrcB :
                       (Operation == OP_SUB) ? SrcA - SrcB :
                       (Operation == OP_EQ)  ? {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB} :
                                               '0;
endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick using a mask above last_grant with fallback to lowest requester
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    logic [NUM_REQ-1:0] masked;
    logic [ID_W-1:0]    masked_idx;
    logic [ID_W-1:0]    any_idx;
    always_comb begin
        masked     = '0;
        masked_idx = '0;
        any_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) masked[i] = req[i] && (i > int'(last_grant));
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) masked_idx = ID_W'(i);
            if (req[i]) any_idx = ID_W'(i);
        end
        grant_idx = |masked ? masked_idx : any_idx;
        grant     = (en && |req) ? NUM_REQ'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one alu between NUM_REQ requesters, one op in flight.
// Define ALU_SHARE_B2B_EN to let the response handshake cycle accept the next request directly.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_result,
    output logic [ID_W-1:0]                  rsp_id,
    output logic                             busy
);
    share_state_t             state;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          owner;
    logic [DATA_WIDTH-1:0]    srca_q;
    logic [DATA_WIDTH-1:0]    srcb_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          grant_idx;
    logic                     hs;
    logic                     arb_en;
    logic                     take;
    assign hs = (state == RESP) && rsp_ready[owner];
`ifdef ALU_SHARE_B2B_EN
    assign arb_en = rst_n && ((state == IDLE) || hs);
`else
    assign arb_en = rst_n && (state == IDLE);
`endif
    assign take      = |grant;
    assign req_ready = grant;
    assign busy      = state != IDLE;
    // in RESP the pointer is taken from owner so the arbiter already sees it advanced past g
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req        (req_valid),
        .last_grant ((state == RESP) ? owner : last_grant),
        .en         (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );
    alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
        .SrcA      (srca_q),
        .SrcB      (srcb_q),
        .Operation (op_q),
        .ALUResult (alu_result)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            owner      <= '0;
            srca_q     <= '0;
            srcb_q     <= '0;
            op_q       <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            if (take) begin
                owner  <= grant_idx;
                srca_q <= req_srca[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                srcb_q <= req_srcb[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                op_q   <= req_op[int'(grant_idx)*OPCODE_LENGTH +: OPCODE_LENGTH];
            end
            case (state)
                IDLE: state <= take ? EXEC : IDLE;
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= owner;
                    rsp_valid  <= NUM_REQ'(1) << owner;
                    state      <= RESP;
                end
                RESP: if (hs) begin
                    rsp_valid  <= '0;
                    last_grant <= owner;
                    state      <= take ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
